// File: rtl/ge_stage_seq.sv
// Sequential multi-stage GE game: per-stage pass/fail with a saturating bonus carried forward.
// Optional feature: define GE_RETRY_EN to allow one retry of a failed stage per game (adds retry_used).
module ge_stage_seq #(
  parameter int NUM_STAGES = 4,
  parameter int IN_W       = 3,
  parameter int BONUS_W    = 2,
  parameter int PASS_TH    = 10,
  parameter int SCORE_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               slide,
  input  logic [IN_W-1:0]               timing,
  input  logic [IN_W-1:0]               luck,
  output logic                          busy,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic [BONUS_W-1:0]            bonus,
  output logic                          done,
  output logic                          win,
  output logic [$clog2(NUM_STAGES)-1:0] fail_stage,
  output logic [SCORE_W-1:0]            total_score
`ifdef GE_RETRY_EN
  ,
  output logic                          retry_used
`endif
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int SUM_W = IN_W + 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [BONUS_W-1:0] BONUS_MAX  = '1;
  localparam logic [SUM_W-1:0]   PASS_TH_S  = SUM_W'(PASS_TH);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   stage_idx_q, stage_idx_d;
  logic [BONUS_W-1:0] bonus_q, bonus_d;
  logic               win_q, win_d;
  logic [IDX_W-1:0]   fail_stage_q, fail_stage_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               retry_q, retry_d;

  logic               hs;
  logic               pass;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   over;
  logic [BONUS_W-1:0] bonus_carry;
  logic [SCORE_W:0]   score_ext;
  logic [SCORE_W-1:0] score_sat;

  // Sum is wide enough for three maximal inputs plus the carried bonus.
  assign sum  = SUM_W'(slide) + SUM_W'(timing) + SUM_W'(luck) + SUM_W'(bonus_q);
  assign pass = (sum >= PASS_TH_S);
  assign over = sum - PASS_TH_S;
  assign bonus_carry = (over > SUM_W'(BONUS_MAX)) ? BONUS_MAX : over[BONUS_W-1:0];

  assign score_ext = {1'b0, score_q} + (SCORE_W+1)'(sum);
  assign score_sat = score_ext[SCORE_W] ? SCORE_MAX : score_ext[SCORE_W-1:0];

  assign in_ready = (state_q == ST_RUN);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    stage_idx_d  = stage_idx_q;
    bonus_d      = bonus_q;
    win_d        = win_q;
    fail_stage_d = fail_stage_q;
    score_d      = score_q;
    retry_d      = retry_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          stage_idx_d  = '0;
          bonus_d      = '0;
          win_d        = 1'b0;
          fail_stage_d = '0;
          score_d      = '0;
          retry_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (hs) begin
          score_d = score_sat;
          if (pass) begin
            if (stage_idx_q == LAST_IDX) begin
              win_d   = 1'b1;
              state_d = ST_FIN;
            end else begin
              bonus_d     = bonus_carry;
              stage_idx_d = stage_idx_q + IDX_W'(1);
            end
`ifdef GE_RETRY_EN
          end else if (!retry_q) begin
            // First failure of the game: replay the same stage with no bonus.
            retry_d = 1'b1;
            bonus_d = '0;
`endif
          end else begin
            win_d        = 1'b0;
            fail_stage_d = stage_idx_q;
            state_d      = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_idx_q  <= '0;
      bonus_q      <= '0;
      win_q        <= 1'b0;
      fail_stage_q <= '0;
      score_q      <= '0;
      retry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_idx_q  <= stage_idx_d;
      bonus_q      <= bonus_d;
      win_q        <= win_d;
      fail_stage_q <= fail_stage_d;
      score_q      <= score_d;
      retry_q      <= retry_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_FIN);
  assign stage_idx   = stage_idx_q;
  assign bonus       = bonus_q;
  assign win         = win_q;
  assign fail_stage  = fail_stage_q;
  assign total_score = score_q;

`ifdef GE_RETRY_EN
  assign retry_used = retry_q;
`else
  logic unused_retry;
  assign unused_retry = retry_q;
`endif

endmodule
